// File: rtl/ifq_pkg.sv
// ifq_pkg - shared constants, types and helpers for the instruction fetch queue.
//
//   INSTR_BYTES   : byte stride between sequential fetch PCs
//   IFQ_RESET_PC  : default first fetch address after reset
//   ifq_entry_t   : queue entry {instr, pc} at the default 32/32 widths
//   ifq_ptr_w()   : width of a queue pointer for a given depth
package ifq_pkg;

    localparam int          INSTR_BYTES  = 4;
    localparam int          IFQ_DATA_W   = 32;
    localparam int          IFQ_ADDR_W   = 32;
    localparam logic [31:0] IFQ_RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic [IFQ_DATA_W-1:0] instr;
        logic [IFQ_ADDR_W-1:0] pc;
    } ifq_entry_t;

    function automatic int ifq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ifq_ram.sv
// ifq_ram - queue storage: DEPTH x WIDTH, one synchronous write port and one
// asynchronous (fall-through) read port. Storage is not reset; the
// occupancy count in the parent decides which entries are meaningful.
//
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : read data, combinational from raddr_i
module ifq_ram
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW   = ifq_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue - instruction fetch front-end. Issues sequential PC reads to
// a single-cycle-latency instruction SRAM and buffers the returned words,
// tagged with their PC, in a DEPTH-entry queue drained by decode through a
// valid/ready handshake. A redirect flushes the queue and any in-flight read
// and restarts fetch at the new (word-aligned) PC.
//
// Optional feature macro: IFQ_BYPASS_EN. When defined, a return arriving at
// an empty queue is presented to decode in the same cycle; if accepted it is
// never written into the queue.
//
//   clk, rst         : clock, asynchronous active-high reset
//   inst_sram_en     : SRAM read request this cycle
//   inst_sram_addr   : SRAM read address
//   inst_sram_rdata  : SRAM read data, valid the cycle after a request
//   redirect_i       : flush and restart fetch
//   redirect_pc_i    : restart PC (bits [1:0] ignored)
//   deq_valid        : head entry available
//   deq_ready        : decode accepts head entry
//   deq_instr        : head instruction
//   deq_pc           : head PC
//   count_o          : queue occupancy
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC),
    localparam int               PW       = ifq_ptr_w(DEPTH),
    localparam int               CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              inst_sram_en,
    output logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_rdata,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_instr,
    output logic [ADDR_W-1:0] deq_pc,
    output logic [CW-1:0]     count_o
);

    localparam int EW = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic              issue, ret, byp, deq_fire, enq, pop;
    logic [EW-1:0]     rd_entry;

    // Credit covers stored entries plus the outstanding read only; a
    // same-cycle dequeue is deliberately not counted as free space.
    assign issue = ~rst & ~redirect_i & ((int'(count_q) + int'(inflight_q)) < DEPTH);
    assign ret   = inflight_q & ~redirect_i;

`ifdef IFQ_BYPASS_EN
    assign byp = ret & (count_q == '0);
`else
    assign byp = 1'b0;
`endif

    assign deq_valid = ((count_q != '0) | byp) & ~redirect_i;
    assign deq_fire  = deq_valid & deq_ready;
    assign pop       = deq_fire & ~byp;
    // A bypassed word that decode takes straight away never touches the queue.
    assign enq       = ret & ~(byp & deq_ready);

    assign deq_instr = byp ? inst_sram_rdata : rd_entry[EW-1 -: DATA_W];
    assign deq_pc    = byp ? inflight_pc_q   : rd_entry[ADDR_W-1:0];

    assign inst_sram_en   = issue;
    assign inst_sram_addr = fetch_pc_q;
    assign count_o        = count_q;

    ifq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk     (clk),
        .we_i    (enq),
        .waddr_i (tail_q),
        .wdata_i ({inst_sram_rdata, inflight_pc_q}),
        .raddr_i (head_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~ADDR_W'(3);
            head_d     = tail_q;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
            if (enq)   tail_d     = tail_q + PW'(1);
            if (pop)   head_d     = head_q + PW'(1);
            if (enq && !pop)      count_d = count_q + CW'(1);
            else if (pop && !enq) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= fetch_pc_q;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule
